// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: bundles the requester strobe buses and the transmitter
// byte port that the arbiter sits between.
//   req_dat  [N*8]  byte from requester i at bits [8i+7:8i]
//   req_last [N]    byte ends requester i's message
//   req_we   [N]    write enable per requester
//   req_stb  [N]    strobe, held until the matching ack
//   req_ack  [N]    one-cycle ack per requester
//   tx_dat   [8]    byte to the transmitter
//   tx_we/tx_stb    write enable / strobe to the transmitter
//   tx_ack          transmitter ack
//   tx_full         transmitter FIFO full
// slave  = arbiter view, master = requester/transmitter environment view.
interface uart_tx_arbiter_if #(
  parameter int N = 2
);
  logic [N*8-1:0] req_dat;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_we;
  logic [N-1:0]   req_stb;
  logic [N-1:0]   req_ack;
  logic [7:0]     tx_dat;
  logic           tx_we;
  logic           tx_stb;
  logic           tx_ack;
  logic           tx_full;

  modport slave (
    input  req_dat, req_last, req_we, req_stb, tx_ack, tx_full,
    output req_ack, tx_dat, tx_we, tx_stb
  );

  modport master (
    output req_dat, req_last, req_we, req_stb, tx_ack, tx_full,
    input  req_ack, tx_dat, tx_we, tx_stb
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one 8-bit UART TX byte port between N write-only
// requesters. Arbitration is per message: the owner keeps the grant until it
// writes a byte flagged last; messages are granted round-robin.
// Ports:
//   clk      system clock
//   rst      synchronous reset, active-high
//   bus      uart_tx_arbiter_if.slave (requester buses + transmitter port)
//   grant_o  one-hot current owner, 0 when idle
//   busy_o   a message is in progress
// Optional: define UART_ARB_TIMEOUT_EN to revoke a grant after TIMEOUT
// cycles in OWN with the owner inactive.
//
// state | meaning
// IDLE  | no owner, searching from ptr for an active requester
// OWN   | owner granted, waiting for its next byte (and tx not full)
// SEND  | byte on the transmitter port, waiting for tx_ack
// RESP  | ack pulse visible to the owner; release on last byte
module uart_tx_arbiter #(
  parameter int N       = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  uart_tx_arbiter_if.slave bus,
  output logic [N-1:0]     grant_o,
  output logic             busy_o
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  if (N < 2 || N > 8 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_param
    $error("uart_tx_arbiter: N must be 2..8 and TIMEOUT 1..65535");
  end

  typedef enum logic [1:0] {IDLE, OWN, SEND, RESP} state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   grant_q, grant_d;
  logic [N-1:0]   req_ack_q, req_ack_d;
  logic [PW-1:0]  owner_q, owner_d;
  logic [PW-1:0]  ptr_q, ptr_d;
  logic           last_q, last_d;
  logic [7:0]     tx_dat_q, tx_dat_d;
  logic           tx_stb_q, tx_stb_d;
  logic           busy_q, busy_d;

  logic [N-1:0]   act;
  logic           owner_act;
  logic           tmo_hit;
  logic           found;
  logic [PW-1:0]  pick_idx;
  logic [PW-1:0]  next_owner;

  assign act        = bus.req_stb & bus.req_we;
  assign owner_act  = act[owner_q];
  assign next_owner = (int'(owner_q) == N - 1) ? '0 : owner_q + PW'(1);

`ifdef UART_ARB_TIMEOUT_EN
  logic [15:0] tmo_q, tmo_d;

  // Counts only OWN cycles with the owner inactive; anything outside OWN
  // (including a byte being issued) clears it. A full-stall with the owner
  // active holds the count.
  always_comb begin
    tmo_d = '0;
    if (state_q == OWN) begin
      if (!owner_act) tmo_d = tmo_q + 16'd1;
      else            tmo_d = tmo_q;
    end
  end

  assign tmo_hit = (state_q == OWN) && !owner_act && (tmo_q + 16'd1 == 16'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (rst) tmo_q <= '0;
    else     tmo_q <= tmo_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // First active requester searching ptr, ptr+1, ... mod N.
  always_comb begin
    int idx;
    found    = 1'b0;
    pick_idx = '0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= N) idx = idx - N;
      if (!found && act[idx]) begin
        found    = 1'b1;
        pick_idx = PW'(idx);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    req_ack_d = '0;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    last_d    = last_q;
    tx_dat_d  = tx_dat_q;
    tx_stb_d  = tx_stb_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = N'(1) << pick_idx;
          owner_d = pick_idx;
          state_d = OWN;
        end
      end
      OWN: begin
        if (owner_act) begin
          if (!bus.tx_full) begin
            tx_dat_d = bus.req_dat[int'(owner_q)*8 +: 8];
            last_d   = bus.req_last[owner_q];
            tx_stb_d = 1'b1;
            state_d  = SEND;
          end
        end else if (tmo_hit) begin
          grant_d = '0;
          ptr_d   = next_owner;
          state_d = IDLE;
        end
      end
      SEND: begin
        if (bus.tx_ack) begin
          tx_stb_d  = 1'b0;
          req_ack_d = grant_q;
          state_d   = RESP;
        end
      end
      RESP: begin
        if (last_q) begin
          grant_d = '0;
          ptr_d   = next_owner;
          state_d = IDLE;
        end else begin
          state_d = OWN;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      req_ack_q <= '0;
      owner_q   <= '0;
      ptr_q     <= '0;
      last_q    <= 1'b0;
      tx_dat_q  <= '0;
      tx_stb_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      req_ack_q <= req_ack_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      last_q    <= last_d;
      tx_dat_q  <= tx_dat_d;
      tx_stb_q  <= tx_stb_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.req_ack = req_ack_q;
  assign bus.tx_dat  = tx_dat_q;
  assign bus.tx_stb  = tx_stb_q;
  assign bus.tx_we   = tx_stb_q;
  assign grant_o     = grant_q;
  assign busy_o      = busy_q;
endmodule
